// File: rtl/uart_mmio_bridge_pkg.sv
// Shared types and frame byte codes for the UART-to-MMIO bridge.
// Command/response encodings match the host-side tool.
package uart_mmio_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    READ,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

endpackage

// File: rtl/uart_mmio_bridge_timer.sv
// Inter-byte watchdog for the bridge; expired while enabled at TIMEOUT-1.
// Used only when UART_BRIDGE_TIMEOUT_EN is defined.
module uart_mmio_bridge_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// UART byte-stream to single-beat MMIO initiator ('W'/'R' frames).
// Optional inter-byte timeout: define UART_BRIDGE_TIMEOUT_EN.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               wr_en_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [D_WIDTH-1:0] wr_data_o,
  output logic               rd_en_o,
  output logic [A_WIDTH-1:0] rd_addr_o,
  input  logic [D_WIDTH-1:0] rd_data_i
);

  localparam int NA = A_WIDTH / 8;
  localparam int ND = D_WIDTH / 8;
  localparam int NM = (NA > ND) ? NA : ND;
  localparam int CW = $clog2(NM + 1);

  if (A_WIDTH % 8 != 0 || D_WIDTH % 8 != 0 || A_WIDTH == 0 ||
      D_WIDTH == 0 || TIMEOUT < 1) begin : g_param_err
    $error("uart_mmio_bridge: widths must be nonzero multiples of 8");
  end

  state_e               state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rx_hs, tx_hs, tmo;

  assign rx_hs = rx_valid_i && rx_ready_o;
  assign tx_hs = tx_valid_o && tx_ready_i;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic tmr_clr, tmr_en;

  assign tmr_clr = rx_hs || (state_q == IDLE);
  assign tmr_en  = (state_q == ADDR) || (state_q == DATA);

  uart_mmio_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (tmr_clr),
    .enable_i  (tmr_en),
    .expired_o (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rx_hs) begin
          if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
            cmd_d   = rx_data_i;
            cnt_d   = '0;
            state_d = ADDR;
          end else begin
            buf_d[D_WIDTH-1 -: 8] = RSP_ERR;
            cnt_d   = CW'(1);
            state_d = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_hs) begin
          addr_d = A_WIDTH'({addr_q, rx_data_i});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(NA - 1)) begin
            cnt_d   = '0;
            state_d = (cmd_q == CMD_WR) ? DATA : READ;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (rx_hs) begin
          buf_d = D_WIDTH'({buf_q, rx_data_i});
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ND - 1)) begin
            state_d = WRITE;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        buf_d[D_WIDTH-1 -: 8] = RSP_ACK;
        cnt_d   = CW'(1);
        state_d = RESP;
      end
      READ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        buf_d   = rd_data_i;
        cnt_d   = CW'(ND);
        state_d = RESP;
      end
      RESP: begin
        if (tx_hs) begin
          buf_d = buf_q << 8;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    wr_en_o    = 1'b0;
    rd_en_o    = 1'b0;
    unique case (state_q)
      IDLE, ADDR, DATA: rx_ready_o = 1'b1;
      WRITE:            wr_en_o    = 1'b1;
      READ:             rd_en_o    = 1'b1;
      RESP:             tx_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign tx_data_o = tx_valid_o ? buf_q[D_WIDTH-1 -: 8] : 8'h00;
  assign wr_addr_o = addr_q;
  assign rd_addr_o = addr_q;
  assign wr_data_o = buf_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge (A_WIDTH=8, D_WIDTH=32, TIMEOUT=100).
// Build with UART_BRIDGE_TIMEOUT_EN to exercise the abandon path.
module tb_uart_mmio_bridge;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i = '0;

  int n_chk = 0;
  int n_err = 0;

  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0;
  int          wr_cyc = 0, rd_cyc = 0, tx_cyc = 0;
  logic [7:0]  wr_addr_cap = '0, rd_addr_cap = '0;
  logic [31:0] wr_data_cap = '0;
  logic        txv_q = 1'b0;

  uart_mmio_bridge #(
    .A_WIDTH (8),
    .D_WIDTH (32),
    .TIMEOUT (100)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] slave_val(input logic [7:0] a);
    case (a)
      8'h0C:   return 32'h1234_5678;
      8'h00:   return 32'hCAFE_F00D;
      8'h04:   return 32'hA5A5_5A5A;
      default: return 32'hDEAD_0000;
    endcase
  endfunction

  // Registered slave plus bus/tx monitors
  always @(posedge clk_i) begin
    cyc   <= cyc + 1;
    txv_q <= tx_valid_o;
    if (rd_en_o) begin
      rd_data_i   <= slave_val(rd_addr_o);
      rd_cnt      <= rd_cnt + 1;
      rd_cyc      <= cyc;
      rd_addr_cap <= rd_addr_o;
    end
    if (wr_en_o) begin
      wr_cnt      <= wr_cnt + 1;
      wr_cyc      <= cyc;
      wr_addr_cap <= wr_addr_o;
      wr_data_cap <= wr_data_o;
    end
    if (tx_valid_o && !txv_q) tx_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(posedge clk_i);
      if (rx_ready_o) break;
    end
    #1 rx_valid_i = 1'b0;
    chk("rx_accept", 32'(n < 100), 32'd1);
  endtask

  task automatic get_byte(output logic [7:0] b, input int stall);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (tx_valid_o) break;
    end
    chk("tx_valid", 32'(tx_valid_o), 32'd1);
    b = tx_data_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk("tx_hold", {24'h0, tx_data_o}, {24'h0, b});
      chk("tx_vhold", 32'(tx_valid_o), 32'd1);
      chk("rx_blocked", 32'(rx_ready_o), 32'd0);
    end
    tx_ready_i = 1'b1;
    @(posedge clk_i);
    #1 tx_ready_i = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d,
                              input int w0, input int r0);
    logic [7:0] b;
    get_byte(b, 0);
    chk("wr_resp", {24'h0, b}, 32'h4B);
    chk("wr_pulses", 32'(wr_cnt - w0), 32'd1);
    chk("wr_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("wr_addr", {24'h0, wr_addr_cap}, {24'h0, a});
    chk("wr_data", wr_data_cap, d);
    chk("wr_lat", 32'(tx_cyc - wr_cyc), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    send(8'h57);
    send(a);
    for (int i = 0; i < 4; i++) send(d[31-8*i -: 8]);
    expect_write(a, d, w0, r0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp,
                         input int stall, input bit junk);
    logic [7:0] b;
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    send(8'h52);
    send(a);
    if (junk) begin
      repeat (3) @(negedge clk_i);
      rx_data_i  = 8'h57;
      rx_valid_i = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      get_byte(b, stall);
      chk("rd_byte", {24'h0, b}, {24'h0, exp[31-8*i -: 8]});
    end
    rx_valid_i = 1'b0;
    chk("rd_pulses", 32'(rd_cnt - r0), 32'd1);
    chk("rd_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("rd_addr", {24'h0, rd_addr_cap}, {24'h0, a});
    chk("rd_lat", 32'(tx_cyc - rd_cyc), 32'd2);
    @(negedge clk_i);
    chk("rd_idle", 32'(rx_ready_o), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int w0, r0;

    repeat (3) @(negedge clk_i);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_rd_en", 32'(rd_en_o), 32'd0);
    chk("rst_addr", {24'h0, wr_addr_o}, 32'h0);
    chk("rst_buf", wr_data_o, 32'h0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    do_write(8'h04, 32'h0000_9600);
    do_read(8'h0C, 32'h1234_5678, 0, 1'b0);

    // Unknown command byte
    w0 = wr_cnt;
    r0 = rd_cnt;
    send(8'hAA);
    get_byte(b, 0);
    chk("err_resp", {24'h0, b}, 32'h3F);
    chk("err_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("err_no_rd", 32'(rd_cnt - r0), 32'd0);
    do_read(8'h00, 32'hCAFE_F00D, 0, 1'b0);

    // Stalled response with rx traffic offered during RESP
    do_read(8'h0C, 32'h1234_5678, 10, 1'b1);
    do_read(8'h00, 32'hCAFE_F00D, 0, 1'b0);

    // Reset mid-frame
    w0 = wr_cnt;
    send(8'h57);
    send(8'h04);
    send(8'h00);
    send(8'h00);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rx_ready_o), 32'd1);
    chk("mid_rst_txv", 32'(tx_valid_o), 32'd0);
    chk("mid_rst_wr", 32'(wr_en_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("mid_rst_nowr", 32'(wr_cnt - w0), 32'd0);
    do_write(8'h10, 32'hDEAD_BEEF);

    // Long inter-byte gap
    w0 = wr_cnt;
    r0 = rd_cnt;
    send(8'h57);
    send(8'h04);
    repeat (102) @(negedge clk_i);
    chk("gap_no_tx", 32'(tx_valid_o), 32'd0);
    chk("gap_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("gap_no_wr", 32'(wr_cnt - w0), 32'd0);
`ifndef UART_BRIDGE_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) send(8'(i));
    expect_write(8'h04, 32'h0102_0304, w0, r0);
`endif
    do_read(8'h04, 32'hA5A5_5A5A, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
